// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the write-back stage.
//   ld_type_e   - load extension type carried from the M stage
//   wb_sel_e    - write-back source select
//   LINK_OFFSET - link address offset (PC of the instruction after the delay slot)
package wb_pkg;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_type_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2
    } wb_sel_e;

    localparam int unsigned LINK_OFFSET = 8;

endpackage

// File: rtl/load_ext.sv
// load_ext: combinational load byte/halfword extraction and extension.
// Ports:
//   rdata   in  DATA_W  raw aligned word from data memory
//   addr_lo in  2       low effective-address bits (little-endian lane select)
//   ld_type in  3       load type (wb_pkg::ld_type_e encoding)
//   ext     out DATA_W  extended load value
// Halfword loads use addr_lo[1] only; alignment is enforced upstream.
// Unknown ld_type encodings pass the full word through.
module load_ext
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        ld_type,
    output logic [DATA_W-1:0] ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = '0;
        case (addr_lo)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = '0;
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext = rdata;
        case (ld_type_e'(ld_type))
            LD_W:  ext = rdata;
            LD_B:  ext = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
            LD_BU: ext = {{(DATA_W-8){1'b0}}, byte_lane};
            LD_H:  ext = {{(DATA_W-16){half_lane[15]}}, half_lane};
            LD_HU: ext = {{(DATA_W-16){1'b0}}, half_lane};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline stage of the five-stage MIPS core.
// Registers the M-stage result, extends loads, selects the write-back value
// and drives the GRF write port plus forwarding info and a retire counter.
// Ports:
//   clk, reset (async, active-low)
//   m_valid/m_ready handshake; m_pc, m_alu, m_mem_rdata, m_addr_lo,
//   m_ld_type, m_wb_sel, m_rd, m_we: M-stage instruction fields
//   flush (drop W on next edge), w_stall (hold W, GRF busy)
//   reg_we, reg_wa, reg_wd, w_pc: GRF write port and trace PC
//   fwd_valid: W holds a pending non-$0 write (independent of stall)
//   retired_cnt: count of retired valid instructions (wraps)
// Configuration macro: WB_TRACE_EN prints each commit as "@pc: $rd <= data".
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [DATA_W-1:0] m_pc,
    input  logic [DATA_W-1:0] m_alu,
    input  logic [DATA_W-1:0] m_mem_rdata,
    input  logic [1:0]        m_addr_lo,
    input  logic [2:0]        m_ld_type,
    input  logic [1:0]        m_wb_sel,
    input  logic [REG_AW-1:0] m_rd,
    input  logic              m_we,
    input  logic              flush,
    input  logic              w_stall,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_wa,
    output logic [DATA_W-1:0] reg_wd,
    output logic [DATA_W-1:0] w_pc,
    output logic              fwd_valid,
    output logic [31:0]       retired_cnt
);

    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        addr_lo;
    logic [2:0]        ld_type;
    wb_sel_e           wb_sel;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic [DATA_W-1:0] ld_value;

    assign m_ready = !w_stall;

    // Flush beats stall beats capture; an idle M stage captures a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid   <= 1'b0;
            pc      <= '0;
            alu     <= '0;
            rdata   <= '0;
            addr_lo <= '0;
            ld_type <= '0;
            wb_sel  <= WB_ALU;
            rd      <= '0;
            we      <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!w_stall) begin
            valid   <= m_valid;
            pc      <= m_pc;
            alu     <= m_alu;
            rdata   <= m_mem_rdata;
            addr_lo <= m_addr_lo;
            ld_type <= m_ld_type;
            wb_sel  <= wb_sel_e'(m_wb_sel);
            rd      <= m_rd;
            we      <= m_we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt <= '0;
        end else if (valid && !w_stall && !flush) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end

    load_ext #(
        .DATA_W(DATA_W)
    ) u_load_ext (
        .rdata  (rdata),
        .addr_lo(addr_lo),
        .ld_type(ld_type),
        .ext    (ld_value)
    );

    // Encoding 3 of wb_sel falls into the default ALU path.
    always_comb begin
        reg_wd = alu;
        case (wb_sel)
            WB_ALU:  reg_wd = alu;
            WB_MEM:  reg_wd = ld_value;
            WB_LINK: reg_wd = pc + DATA_W'(LINK_OFFSET);
            default: reg_wd = alu;
        endcase
    end

    assign reg_wa    = rd;
    assign w_pc      = pc;
    assign fwd_valid = valid && we && (rd != '0);
    // Masking with the stall guarantees a single commit across a held entry.
    assign reg_we    = fwd_valid && !w_stall;

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (reg_we) begin
            $display("@%h: $%d <= %h", w_pc, reg_wa, reg_wd);
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_pc;
    logic [31:0] m_alu;
    logic [31:0] m_mem_rdata;
    logic [1:0]  m_addr_lo;
    logic [2:0]  m_ld_type;
    logic [1:0]  m_wb_sel;
    logic [4:0]  m_rd;
    logic        m_we;
    logic        flush;
    logic        w_stall;
    logic        reg_we;
    logic [4:0]  reg_wa;
    logic [31:0] reg_wd;
    logic [31:0] w_pc;
    logic        fwd_valid;
    logic [31:0] retired_cnt;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } commit_t;

    commit_t sb[$];
    int      tests   = 0;
    int      fails   = 0;
    int      commits = 0;
    logic [31:0] exp_cnt = 0;

    wb_stage #(
        .DATA_W(32),
        .REG_AW(5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_pc       (m_pc),
        .m_alu      (m_alu),
        .m_mem_rdata(m_mem_rdata),
        .m_addr_lo  (m_addr_lo),
        .m_ld_type  (m_ld_type),
        .m_wb_sel   (m_wb_sel),
        .m_rd       (m_rd),
        .m_we       (m_we),
        .flush      (flush),
        .w_stall    (w_stall),
        .reg_we     (reg_we),
        .reg_wa     (reg_wa),
        .reg_wd     (reg_wd),
        .w_pc       (w_pc),
        .fwd_valid  (fwd_valid),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference write-back value, computed by shifting rather than lane muxing.
    function automatic logic [31:0] model_wd(input logic [31:0] pc, input logic [31:0] alu,
                                             input logic [31:0] rdata, input logic [1:0] lo,
                                             input logic [2:0] ldt, input logic [1:0] sel);
        logic [31:0] bsh;
        logic [31:0] hsh;
        logic [31:0] ld;
        bsh = rdata >> (8 * lo);
        hsh = rdata >> (16 * lo[1]);
        case (ldt)
            3'd1:    ld = {{24{bsh[7]}}, bsh[7:0]};
            3'd2:    ld = {24'h0, bsh[7:0]};
            3'd3:    ld = {{16{hsh[15]}}, hsh[15:0]};
            3'd4:    ld = {16'h0, hsh[15:0]};
            default: ld = rdata;
        endcase
        if (sel == 2'd1)      return ld;
        else if (sel == 2'd2) return pc + 32'd8;
        else                  return alu;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one M-stage instruction for one edge; record expected commit/count.
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [1:0] lo, input logic [2:0] ldt, input logic [1:0] sel,
                         input logic [4:0] rd, input logic we, input bit push, input bit counts);
        commit_t c;
        m_valid = 1'b1; m_pc = pc; m_alu = alu; m_mem_rdata = rdata;
        m_addr_lo = lo; m_ld_type = ldt; m_wb_sel = sel; m_rd = rd; m_we = we;
        if (push) begin
            c.wa = rd;
            c.wd = model_wd(pc, alu, rdata, lo, ldt, sel);
            c.pc = pc;
            sb.push_back(c);
        end
        if (counts) exp_cnt++;
        step();
    endtask

    task automatic idle();
        m_valid = 1'b0;
        step();
    endtask

    // Commit monitor: every GRF write must match the oldest expected commit.
    always @(negedge clk) begin
        if (reg_we === 1'b1) begin
            commit_t c;
            commits++;
            if (sb.size() == 0) begin
                check("unexp_commit", {31'b0, reg_we}, 32'd0);
            end else begin
                c = sb.pop_front();
                check("commit_wa", {27'b0, reg_wa}, {27'b0, c.wa});
                check("commit_wd", reg_wd, c.wd);
                check("commit_pc", w_pc, c.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        reset = 1'b0; m_valid = 1'b0; m_pc = '0; m_alu = '0; m_mem_rdata = '0;
        m_addr_lo = '0; m_ld_type = '0; m_wb_sel = '0; m_rd = '0; m_we = 1'b0;
        flush = 1'b0; w_stall = 1'b0;

        #2;
        check("rst_reg_we", {31'b0, reg_we}, 32'd0);
        check("rst_reg_wa", {27'b0, reg_wa}, 32'd0);
        check("rst_reg_wd", reg_wd, 32'd0);
        check("rst_w_pc", w_pc, 32'd0);
        check("rst_fwd", {31'b0, fwd_valid}, 32'd0);
        check("rst_cnt", retired_cnt, 32'd0);
        check("rst_ready", {31'b0, m_ready}, 32'd1);
        w_stall = 1'b1; #1;
        check("rst_ready_stall", {31'b0, m_ready}, 32'd0);
        w_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        step();

        // Basic ALU write-back and counter 0 -> 1.
        issue(32'h0000_1000, 32'h0000_1234, 32'h0, 2'd0, LD_W, WB_ALU, 5'd5, 1'b1, 1, 1);
        check("alu_cnt_before", retired_cnt, exp_cnt - 32'd1);
        check("alu_reg_we", {31'b0, reg_we}, 32'd1);
        check("alu_reg_wd", reg_wd, 32'h0000_1234);
        idle();
        check("alu_cnt_after", retired_cnt, exp_cnt);

        // Load extension variants, back to back.
        issue(32'h1004, 32'h0, 32'h80FF_7F01, 2'd2, LD_B,  WB_MEM, 5'd6,  1'b1, 1, 1);
        issue(32'h1008, 32'h0, 32'h80FF_7F01, 2'd3, LD_BU, WB_MEM, 5'd7,  1'b1, 1, 1);
        issue(32'h100C, 32'h0, 32'h80FF_7F01, 2'd2, LD_H,  WB_MEM, 5'd8,  1'b1, 1, 1);
        check("ldh_wd", reg_wd, 32'hFFFF_80FF);
        issue(32'h1010, 32'h0, 32'h80FF_7F01, 2'd1, LD_HU, WB_MEM, 5'd9,  1'b1, 1, 1);
        issue(32'h1014, 32'h0, 32'h80FF_7F01, 2'd1, LD_W,  WB_MEM, 5'd10, 1'b1, 1, 1);
        issue(32'h1018, 32'h0, 32'h80FF_7F01, 2'd0, LD_B,  WB_MEM, 5'd11, 1'b1, 1, 1);
        issue(32'h101C, 32'h0, 32'h0000_8000, 2'd3, LD_H,  WB_MEM, 5'd12, 1'b1, 1, 1);
        // Link address and the unused wb_sel encoding.
        issue(32'h0000_3000, 32'h5555, 32'h0, 2'd0, LD_W, WB_LINK, 5'd31, 1'b1, 1, 1);
        check("link_wa", {27'b0, reg_wa}, 32'd31);
        check("link_wd", reg_wd, 32'h0000_3008);
        issue(32'hFFFF_FFFC, 32'h0, 32'h0, 2'd0, LD_W, WB_LINK, 5'd30, 1'b1, 1, 1);
        issue(32'h1020, 32'hABCD_0001, 32'h0, 2'd0, LD_W, 2'd3, 5'd4, 1'b1, 1, 1);
        // we = 0 retires but does not commit.
        issue(32'h1024, 32'h77, 32'h0, 2'd0, LD_W, WB_ALU, 5'd4, 1'b0, 0, 1);
        idle();
        check("burst_cnt", retired_cnt, exp_cnt);

        // Multi-cycle stall: one commit on release.
        issue(32'h2000, 32'h0000_CAFE, 32'h0, 2'd0, LD_W, WB_ALU, 5'd12, 1'b1, 1, 1);
        m_valid = 1'b0; w_stall = 1'b1;
        c0 = commits;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_reg_we", {31'b0, reg_we}, 32'd0);
            check("stall_fwd", {31'b0, fwd_valid}, 32'd1);
            check("stall_ready", {31'b0, m_ready}, 32'd0);
            check("stall_cnt", retired_cnt, exp_cnt - 32'd1);
            @(posedge clk);
        end
        #1;
        w_stall = 1'b0;
        step();
        check("stall_one_commit", commits - c0, 32'd1);
        check("stall_cnt_after", retired_cnt, exp_cnt);

        // Write to $0 is never committed but still retires.
        issue(32'h2004, 32'h1111, 32'h0, 2'd0, LD_W, WB_ALU, 5'd0, 1'b1, 0, 1);
        check("r0_reg_we", {31'b0, reg_we}, 32'd0);
        check("r0_fwd", {31'b0, fwd_valid}, 32'd0);
        idle();
        check("r0_cnt", retired_cnt, exp_cnt);

        // Flush during stall drops the held entry uncounted.
        issue(32'h2008, 32'h2222, 32'h0, 2'd0, LD_W, WB_ALU, 5'd13, 1'b1, 0, 0);
        m_valid = 1'b0; w_stall = 1'b1;
        step();
        check("fl_fwd_held", {31'b0, fwd_valid}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0; w_stall = 1'b0;
        #1;
        check("fl_fwd", {31'b0, fwd_valid}, 32'd0);
        check("fl_reg_we", {31'b0, reg_we}, 32'd0);
        step();
        check("fl_cnt", retired_cnt, exp_cnt);

        // Reset mid-stall discards the held entry.
        issue(32'h200C, 32'h3333, 32'h0, 2'd0, LD_W, WB_ALU, 5'd14, 1'b1, 0, 0);
        m_valid = 1'b0; w_stall = 1'b1;
        step();
        #2;
        reset = 1'b0;
        #1;
        exp_cnt = 0;
        check("mrst_reg_we", {31'b0, reg_we}, 32'd0);
        check("mrst_reg_wa", {27'b0, reg_wa}, 32'd0);
        check("mrst_reg_wd", reg_wd, 32'd0);
        check("mrst_w_pc", w_pc, 32'd0);
        check("mrst_fwd", {31'b0, fwd_valid}, 32'd0);
        check("mrst_cnt", retired_cnt, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) begin reset = 1'b1; w_stall = 1'b0; end
        repeat (3) step();
        check("mrst_cnt_after", retired_cnt, exp_cnt);

        issue(32'h3000, 32'h0000_DEAD, 32'h0, 2'd0, LD_W, WB_ALU, 5'd3, 1'b1, 1, 1);
        idle();
        check("post_rst_cnt", retired_cnt, exp_cnt);
        step();
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
